uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive path: the RX-side counterpart of the TX serializer in the UART block.
//  Oversamples RX_IN, detects start, majority-samples each bit, deserializes LSB-first,
//  checks optional parity and stop bit. Delivers a byte plus a one-cycle DATA_VALID
//  pulse to the RX FIFO / sync stage in the UART clock domain.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame
//  PRESC_W     6   width of PRESCALE port
// PORTS
//  CLK         in   1           UART oversampling clock
//  nRESET      in   1           asynchronous, active-low reset
//  RX_IN       in   1           serial line, idle high (asynchronous to CLK)
//  PRESCALE    in   PRESC_W     oversampling ratio; legal 8, 16, 32
//  PAR_EN      in   1           1 = frame carries a parity bit
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  P_DATA      out  DATA_WIDTH  last good received byte
//  DATA_VALID  out  1           one-cycle pulse: P_DATA updated with a good frame
//  PAR_ERR     out  1           one-cycle pulse: parity mismatch
//  STP_ERR     out  1           one-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, synchronizer flops 1.
//  - RX_IN passes a 2-flop synchronizer (2-cycle latency); all logic uses synced rx.
//  - PRESCALE/PAR_EN/PAR_TYP latched on start detection; constant for that frame.
//  - edge_cnt counts 0..PRESCALE-1 per bit; bit_cnt counts bits within DATA state.
//  - Sample points: edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of the 3,
//    valid in the cycle after edge_cnt = P/2+1.
//  - FSM: IDLE -> START on synced rx 1->0 (edge_cnt cleared to 0 that cycle).
//    START: majority 0 -> continue to DATA at edge_cnt=P-1; majority 1 -> glitch,
//      back to IDLE immediately, no flags raised.
//    DATA: DATA_WIDTH bits shifted in LSB-first; after last bit -> PARITY if
//      PAR_EN else STOP.
//    PARITY: expected = ^data (even) or ~^data (odd); mismatch -> PAR_ERR pulse
//      one cycle after the decision; frame marked bad; -> STOP.
//    STOP: on stop-bit decision return to IDLE immediately (do not wait out the
//      bit) so a back-to-back start edge is caught. Stop=0 -> STP_ERR pulse.
//      Stop=1 and no parity error -> P_DATA <= shift reg, DATA_VALID pulse,
//      both in the cycle after the decision.
//  - Bad frames never update P_DATA and never raise DATA_VALID; P_DATA holds value.
//  - PAR_ERR and STP_ERR may both fire for one frame (different cycles).
//  - Line held low in IDLE after STP_ERR: no new start until rx returns high
//    (start detect requires a 1->0 transition).
//  - nRESET mid-frame: frame abandoned, no flags, state as at reset.
//  - PRESCALE outside {8,16,32}: unsupported, behaviour undefined.
// STRUCTURE
//  - Package uart_pkg: FSM state encoding (IDLE/START/DATA/PARITY/STOP),
//    legal PRESCALE constants, parity-type constants EVEN=0/ODD=1.
//  - Sub-module uart_rx_sampler: owns edge counter and 3-point majority vote,
//    outputs bit_value + bit_strobe + bit_end; FSM, shift reg, checks in top.
// TESTING
//  - P=8, no parity, send 0xA5 + stop 1 -> P_DATA=0xA5, DATA_VALID one pulse, no errs.
//  - P=16, even parity, 0x3C with parity 0 -> valid; same byte parity 1 ->
//    PAR_ERR pulse, no DATA_VALID, P_DATA keeps previous value.
//  - P=32, odd parity, 0x00 parity 1, stop 0 -> STP_ERR pulse, no DATA_VALID.
//  - Low glitch of 2 CLK on idle line, P=8 -> returns to IDLE, no outputs change.
//  - Back-to-back 0x55 then 0xAA, no idle gap, P=8 -> two DATA_VALID pulses, both
//    bytes correct; single-cycle noise flip at one sample point -> byte unchanged.
//  - nRESET asserted mid-DATA bit 4 -> outputs 0; next clean 0x81 frame received OK.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//  - rx_state_t     : receive FSM state encoding
//  - PRESC_*        : supported oversampling ratios
//  - PAR_EVEN/ODD   : parity-type encodings for PAR_TYP
//  - majority3      : 2-of-3 vote used by the bit sampler
//  - expected_parity: parity bit a correct frame carries for given data
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Data is zero-extended by the caller; extra zeros do not change the XOR.
    function automatic logic expected_parity(input logic [31:0] data, input logic typ);
        logic p;
        case (typ)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~(^data);
            default:  p = ^data;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-point majority sampler.
//  clk, rst_n  : clock, asynchronous active-low reset
//  run         : 1 while a frame is being received; 0 holds counter at 0
//  rx          : synchronized serial line
//  presc       : oversampling ratio for the current frame
//  bit_value   : majority of the three centre samples (valid with bit_strobe)
//  bit_strobe  : one-cycle pulse, the cycle after edge count P/2+1
//  bit_end     : high on the last oversampling cycle of a bit (count P-1)
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               rx,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_value,
    output logic               bit_strobe,
    output logic               bit_end
);

    localparam logic [PRESC_W-1:0] ONE_C = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] edge_cnt_r;
    logic [PRESC_W-1:0] half_s;
    logic               hit_a_s;
    logic               hit_b_s;
    logic               hit_c_s;
    logic               last_s;
    logic               samp_a_r;
    logic               samp_b_r;
    logic               bit_value_r;
    logic               bit_strobe_r;

    // Decode the sample points and the bit boundary from the edge counter.
    always_comb begin
        half_s  = presc >> 1;
        hit_a_s = (edge_cnt_r == (half_s - ONE_C));
        hit_b_s = (edge_cnt_r == half_s);
        hit_c_s = (edge_cnt_r == (half_s + ONE_C));
        last_s  = (edge_cnt_r == (presc - ONE_C));
    end

    // Edge counter, sample capture and registered vote/strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r   <= '0;
            samp_a_r     <= 1'b0;
            samp_b_r     <= 1'b0;
            bit_value_r  <= 1'b0;
            bit_strobe_r <= 1'b0;
        end else if (!run) begin
            edge_cnt_r   <= '0;
            samp_a_r     <= 1'b0;
            samp_b_r     <= 1'b0;
            bit_value_r  <= 1'b0;
            bit_strobe_r <= 1'b0;
        end else begin
            edge_cnt_r   <= last_s ? '0 : (edge_cnt_r + ONE_C);
            if (hit_a_s) samp_a_r <= rx;
            if (hit_b_s) samp_b_r <= rx;
            // Third sample is the live line value, voted directly.
            if (hit_c_s) bit_value_r <= majority3(samp_a_r, samp_b_r, rx);
            bit_strobe_r <= hit_c_s;
        end
    end

    assign bit_value  = bit_value_r;
    assign bit_strobe = bit_strobe_r;
    assign bit_end    = last_s;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver - synchronizer, start detect, framing FSM,
// LSB-first deserializer, parity and stop checks.
//  CLK, nRESET  : oversampling clock, asynchronous active-low reset
//  RX_IN        : serial line, idle high, asynchronous to CLK
//  PRESCALE     : oversampling ratio (8/16/32), latched at start detect
//  PAR_EN       : frame carries a parity bit (latched at start detect)
//  PAR_TYP      : 0 even / 1 odd parity (latched at start detect)
//  P_DATA       : last good received byte (held across bad frames)
//  DATA_VALID   : one-cycle pulse when P_DATA is updated
//  PAR_ERR      : one-cycle pulse on parity mismatch
//  STP_ERR      : one-cycle pulse when the stop bit samples 0
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int            BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    logic                  sync1_r;
    logic                  sync2_r;
    logic                  rx_prev_r;
    rx_state_t             state_r;
    rx_state_t             state_s;
    logic [PRESC_W-1:0]    presc_r;
    logic [PRESC_W-1:0]    presc_sel_s;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic                  par_bad_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;

    logic                  bit_value_s;
    logic                  bit_strobe_s;
    logic                  bit_end_s;
    logic                  start_det_s;
    logic                  shift_en_s;
    logic                  bit_inc_s;
    logic                  par_mis_s;
    logic                  frame_ok_s;
    logic                  stp_bad_s;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= RX_IN;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk        (CLK),
        .rst_n      (nRESET),
        .run        (state_r != ST_IDLE),
        .rx         (sync2_r),
        .presc      (presc_r),
        .bit_value  (bit_value_s),
        .bit_strobe (bit_strobe_s),
        .bit_end    (bit_end_s)
    );

    // Unsupported ratios fall back to 16 so the counter always wraps sanely.
    always_comb begin
        if ((PRESCALE == PRESC_W'(PRESC_8)) || (PRESCALE == PRESC_W'(PRESC_16)) ||
            (PRESCALE == PRESC_W'(PRESC_32))) begin
            presc_sel_s = PRESCALE;
        end else begin
            presc_sel_s = PRESC_W'(PRESC_16);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_det_s) state_s = ST_START;
                else             state_s = ST_IDLE;
            end
            ST_START: begin
                // A start bit voting high was a glitch: abandon at once.
                if (bit_strobe_s && bit_value_s) state_s = ST_IDLE;
                else if (bit_end_s)              state_s = ST_DATA;
                else                             state_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_BIT)) begin
                    state_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) state_s = ST_STOP;
                else           state_s = ST_PARITY;
            end
            ST_STOP: begin
                // Leave on the decision so a back-to-back start edge is seen.
                if (bit_strobe_s) state_s = ST_IDLE;
                else              state_s = ST_STOP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath enables and next values of the flags.
    always_comb begin
        start_det_s = (state_r == ST_IDLE) && rx_prev_r && !sync2_r;
        shift_en_s  = (state_r == ST_DATA) && bit_strobe_s;
        bit_inc_s   = (state_r == ST_DATA) && bit_end_s;
        if ((state_r == ST_PARITY) && bit_strobe_s) begin
            par_mis_s = (bit_value_s != expected_parity(32'(shift_r), par_typ_r));
        end else begin
            par_mis_s = 1'b0;
        end
        if ((state_r == ST_STOP) && bit_strobe_s) begin
            stp_bad_s  = !bit_value_s;
            frame_ok_s = bit_value_s && !par_bad_r;
        end else begin
            stp_bad_s  = 1'b0;
            frame_ok_s = 1'b0;
        end
    end

    // Per-frame configuration, captured on the start edge.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            presc_r   <= PRESC_W'(PRESC_8);
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else if (start_det_s) begin
            presc_r   <= presc_sel_s;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
        end
    end

    // Deserializer, bit counter and bad-frame marker.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            par_bad_r <= 1'b0;
        end else if (start_det_s) begin
            bit_cnt_r <= '0;
            par_bad_r <= 1'b0;
        end else begin
            if (shift_en_s) shift_r   <= {bit_value_s, shift_r[DATA_WIDTH-1:1]};
            if (bit_inc_s)  bit_cnt_r <= bit_cnt_r + BIT_ONE;
            if (par_mis_s)  par_bad_r <= 1'b1;
        end
    end

    // Registered outputs: pulses land the cycle after each decision.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            p_data_r     <= '0;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            if (frame_ok_s) p_data_r <= shift_r;
            data_valid_r <= frame_ok_s;
            par_err_r    <= par_mis_s;
            stp_err_r    <= stp_bad_s;
        end
    end

    assign P_DATA     = p_data_r;
    assign DATA_VALID = data_valid_r;
    assign PAR_ERR    = par_err_r;
    assign STP_ERR    = stp_err_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized and directed frames against a frame-level
// event model (expected events queued per frame, matched as pulses appear).
module tb_uart_rx_core;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    localparam logic [1:0] EV_VALID = 2'd1;
    localparam logic [1:0] EV_PAR   = 2'd2;
    localparam logic [1:0] EV_STP   = 2'd3;
    localparam logic [9:0] EV_NONE  = 10'h3ff;

    uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Match one observed pulse against the next expected event.
    task automatic mon_event(input string tag, input logic [9:0] obs);
        logic [9:0] e;
        if (exp_q.size() == 0) e = EV_NONE;
        else                   e = exp_q.pop_front();
        check_eq(tag, 32'(obs), 32'(e));
        if (e[9:8] == EV_VALID) last_good = e[7:0];
        else check_eq({tag, "_hold"}, 32'(P_DATA), 32'(last_good));
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!nRESET) begin
            last_good = 8'h00;
        end else begin
            if (PAR_ERR)    mon_event("par_err", {EV_PAR, 8'h00});
            if (STP_ERR)    mon_event("stp_err", {EV_STP, 8'h00});
            if (DATA_VALID) mon_event("data_valid", {EV_VALID, P_DATA});
        end
    end

    // Drive one frame; the expected outcome is queued from the framing rules.
    // noise_pos: frame bit index (1..8 = data bits) to flip for one cycle, -1 none.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit bad_par, input bit stop, input int noise_pos,
                              input int noise_cyc);
        logic bits[$];
        logic pb;
        bit   perr;
        PRESCALE = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        pb   = ptyp ? ~(^d) : (^d);
        perr = pen && bad_par;
        if (perr) pb = ~pb;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pb);
        bits.push_back(stop);
        if (perr)          exp_q.push_back({EV_PAR, 8'h00});
        if (!stop)         exp_q.push_back({EV_STP, 8'h00});
        if (!perr && stop) exp_q.push_back({EV_VALID, d});
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < p; c++) begin
                RX_IN = bits[b] ^ ((b == noise_pos) && (c == noise_cyc));
                tick(1);
            end
        end
        RX_IN = 1'b1;
        // A low stop bit must see the line high again before the next start.
        if (!stop) tick(p);
    endtask

    initial begin
        int p;
        int pick;
        logic [7:0] d;

        // Reset state
        tick(3);
        check_eq("reset_outputs", {21'h0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR}, 32'h0);
        nRESET = 1'b1;
        tick(4);

        // Directed cases
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 0);
        tick(8);
        check_eq("p_data_a5", 32'(P_DATA), 32'h000000A5);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 0);
        tick(16);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 0);
        tick(16);
        send_frame(32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, -1, 0);
        tick(32);
        check_eq("p_data_after_bad", 32'(P_DATA), 32'h0000003C);

        // Two-cycle low glitch on an idle line
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        tick(2);
        RX_IN = 1'b1;
        tick(24);
        check_eq("glitch_no_change", {21'h0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR},
                 {21'h0, 8'h3C, 3'b000});

        // Back-to-back frames, then single-cycle noise on a centre sample
        send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, 0);
        send_frame(8, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, -1, 0);
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 4, 4);
        tick(12);
        check_eq("p_data_noise", 32'(P_DATA), 32'h0000005A);

        // Reset in the middle of data bit 4
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        d = 8'h6F;
        RX_IN = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            RX_IN = d[i];
            tick(8);
        end
        RX_IN = d[4];
        tick(4);
        nRESET = 1'b0;
        tick(2);
        check_eq("midframe_reset", {21'h0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR}, 32'h0);
        RX_IN = 1'b1;
        tick(2);
        nRESET = 1'b1;
        tick(8);
        send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 0);
        tick(12);
        check_eq("p_data_81", 32'(P_DATA), 32'h00000081);

        // Randomized frames
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(2, 0));
            p = (pick == 0) ? 8 : ((pick == 1) ? 16 : 32);
            d = 8'($urandom);
            send_frame(p, 1'($urandom), 1'($urandom), d,
                       ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0),
                       ($urandom_range(2, 0) == 0) ? int'($urandom_range(8, 1)) : -1,
                       int'($urandom_range(p - 1, 0)));
            tick(int'($urandom_range(p, 0)));
        end
        tick(400);
        check_eq("events_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
